lvds_link_arbiter: RTL and testbench

Round-robin arbiter that shares the single 32-bit transmit flit port of the LVDS serializer among several on-chip requesters, such as the Nios flit path and a loopback/DMA source. It sits between the requesters and the serializer's `enq_tx`/`EN_enq_tx`/`RDY_enq_tx` handshake. Grants are held for whole packets, bounded by a maximum burst length, so one requester cannot starve the others.

---
 rtl/lvds_link_arbiter_pkg.sv | 18 +
 rtl/lvds_link_arbiter_if.sv | 32 +++
 rtl/lvds_link_arbiter_picker.sv | 43 ++++
 rtl/lvds_link_arbiter.sv | 121 ++++++++++++
 tb/tb_lvds_link_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_link_arbiter_pkg.sv
// lvds_arb_pkg
// Shared types and constants for the LVDS transmit-port arbiter.
//   arb_state_t  : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   ARB_BURST_W  : width of the per-grant flit counter
//   ARB_STAT_W   : width of each per-requester statistics counter
//   ARB_STAT_MAX : saturation value of the statistics counters
package lvds_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int ARB_BURST_W = 8;
  localparam int ARB_STAT_W  = 16;
  localparam logic [ARB_STAT_W-1:0] ARB_STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/lvds_link_arbiter_if.sv
// lvds_link_arbiter_if
// Bundles the requester lanes and the serializer enqueue handshake.
//   req_valid/req_data/req_last : requester lanes (lane i at [i*FLIT_W +: FLIT_W])
//   req_ready                   : per-lane consume strobe back to requesters
//   tx_data/EN_tx/RDY_tx        : serializer flit port and handshake
// Modports:
//   slave  : the arbiter side (consumes lanes, drives serializer)
//   master : the environment side (requesters plus serializer)
interface lvds_link_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*FLIT_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FLIT_W-1:0]         tx_data;
  logic                      EN_tx;
  logic                      RDY_tx;

  modport slave (
    input  req_valid, req_data, req_last, RDY_tx,
    output req_ready, tx_data, EN_tx
  );

  modport master (
    output req_valid, req_data, req_last, RDY_tx,
    input  req_ready, tx_data, EN_tx
  );

endinterface

// File: rtl/lvds_link_arbiter_picker.sv
// rr_priority_picker
// Combinational round-robin pick: rotates the request vector so that the
// lane after last_grant sits at bit 0, priority-encodes the lowest set bit,
// then rotates the index back into lane numbering.
//   req        : request vector, one bit per lane
//   last_grant : lane that held the most recent grant (lowest priority now)
//   pick       : winning lane index (meaningful only when any=1)
//   any        : at least one lane is requesting
module rr_priority_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W-1:0]   offset;

  // Rotate so the lane just above last_grant becomes position 0; wrap
  // modulo NUM_REQ so non-power-of-two lane counts still rotate correctly.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rotated[k] = req[(int'(last_grant) + 1 + k) % NUM_REQ];
    end
  end

  // Scan from the top down so the lowest set position is the last one
  // written, which gives lowest-position-wins without a found flag.
  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IDX_W'(k);
    end
  end

  assign pick = IDX_W'((int'(last_grant) + 1 + int'(offset)) % NUM_REQ);
  assign any  = |req;

endmodule

// File: rtl/lvds_link_arbiter.sv
// lvds_link_arbiter
// Round-robin arbiter sharing the serializer's single flit port among
// NUM_REQ requesters. A grant is held for a whole packet, but never longer
// than MAX_BURST transfers, and there is one idle cycle between grants.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   bus         : lvds_link_arbiter_if.slave (requester lanes + serializer)
//   grant_id    : current or most recent granted lane
//   busy        : a grant is active
//   stat_sel    : statistics counter select
//   stat_cnt    : selected statistics counter (registered, 1-cycle latency)
// Build option:
//   LVDS_ARB_STATS_EN : builds saturating per-lane flit counters; when not
//                       defined stat_cnt reads 0 and stat_sel is ignored.
module lvds_link_arbiter
  import lvds_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int FLIT_W    = 32,
  parameter  int MAX_BURST = 8,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lvds_link_arbiter_if.slave    bus,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  busy,
  input  logic [IDX_W-1:0]      stat_sel,
  output logic [ARB_STAT_W-1:0] stat_cnt
);

  localparam logic [ARB_BURST_W-1:0] BURST_LAST = ARB_BURST_W'(MAX_BURST - 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       last_grant;
  logic [ARB_BURST_W-1:0] burst_cnt;
  logic [IDX_W-1:0]       pick;
  logic                   any_req;
  logic                   xfer;
  logic                   release_now;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any_req)
  );

  // Steer the granted lane onto the serializer port. Kept combinational on
  // the registered grant so a ready serializer takes a flit in the very
  // first grant cycle; everything is quiet while idle.
  always_comb begin
    bus.tx_data   = '0;
    bus.EN_tx     = 1'b0;
    bus.req_ready = '0;
    if (state == ARB_GRANT) begin
      bus.tx_data             = bus.req_data[grant_id*FLIT_W +: FLIT_W];
      bus.req_ready[grant_id] = bus.RDY_tx;
      bus.EN_tx               = bus.req_valid[grant_id] & bus.RDY_tx;
    end
  end

  // A grant ends on the packet's last flit or on the transfer that fills
  // the burst budget, whichever comes first.
  assign xfer        = bus.EN_tx;
  assign release_now = xfer & (bus.req_last[grant_id] | (burst_cnt == BURST_LAST));

  // Arbitration FSM. The pick from IDLE is registered, so req_valid never
  // reaches grant_id combinationally. On release the FSM always drops back
  // to IDLE for a cycle; the released lane becomes last_grant and so has
  // the lowest priority in the following arbitration. Stalled cycles hold
  // the grant without touching burst_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      busy       <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (any_req) begin
        grant_id <= pick;
        state    <= ARB_GRANT;
        busy     <= 1'b1;
      end
    end else begin
      if (release_now) begin
        state      <= ARB_IDLE;
        busy       <= 1'b0;
        last_grant <= grant_id;
        burst_cnt  <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

`ifdef LVDS_ARB_STATS_EN
  logic [ARB_STAT_W-1:0] flit_cnt [NUM_REQ];

  // Per-lane transfer counters that stick at their maximum instead of
  // wrapping, plus a registered read port selected by stat_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) flit_cnt[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (xfer && flit_cnt[grant_id] != ARB_STAT_MAX) begin
        flit_cnt[grant_id] <= flit_cnt[grant_id] + 1'b1;
      end
      stat_cnt <= (int'(stat_sel) < NUM_REQ) ? flit_cnt[stat_sel] : '0;
    end
  end
`else
  logic unused_stat_sel;

  assign stat_cnt        = '0;
  assign unused_stat_sel = ^stat_sel;
`endif

endmodule

// File: tb/tb_lvds_link_arbiter.sv
// tb_lvds_link_arbiter
// Directed bench for lvds_link_arbiter (NUM_REQ=4, FLIT_W=32, MAX_BURST=8).
// Each lane is driven by a tiny packet source: lane i sends base+seq flits,
// packets of a fixed length, a fixed number of packets. Per-cycle outputs
// are logged at the falling edge and compared with hand-computed values.
// Define LVDS_ARB_STATS_EN to also exercise the statistics counters.
module tb_lvds_link_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant_id;
  logic        busy;
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;

  int total = 0;
  int bad   = 0;

  lvds_link_arbiter_if #(.NUM_REQ(4), .FLIT_W(32)) bus ();

  lvds_link_arbiter #(.NUM_REQ(4), .FLIT_W(32), .MAX_BURST(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Lane source state
  logic [31:0] base [4];
  int seq [4];
  int flitsLeft [4];
  int pktLen [4];
  int pktsLeft [4];

  // Stall window for RDY_tx, in cycle numbers
  int stallFrom = -1;
  int stallTo   = -1;
  int cyc = 0;

  // Per-cycle logs
  logic        enLog [64];
  logic        busyLog [64];
  logic [1:0]  grantLog [64];
  logic [3:0]  readyLog [64];
  logic [31:0] dataLog [64];
  logic [31:0] trData [$];
  int          trCycle [$];

  // Count a comparison and report it when the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present every lane's current flit on the bus
  task automatic driveLanes();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]        = (flitsLeft[i] > 0);
      bus.req_data[i*32 +: 32] = base[i] + 32'(seq[i]);
      bus.req_last[i]         = (flitsLeft[i] == 1);
    end
  endtask

  // Load a lane with npkts packets of len flits starting at data b
  task automatic applyStimulus(input int lane, input logic [31:0] b,
                               input int len, input int npkts);
    base[lane]      = b;
    seq[lane]       = 0;
    pktLen[lane]    = len;
    pktsLeft[lane]  = npkts;
    flitsLeft[lane] = (npkts > 0) ? len : 0;
    driveLanes();
  endtask

  task automatic clearLanes();
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'h0, 0, 0);
  endtask

  // Step each lane that handed over a flit on the last edge
  task automatic advanceLanes(input logic [3:0] fire);
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        seq[i]++;
        flitsLeft[i]--;
        if (flitsLeft[i] == 0) begin
          pktsLeft[i]--;
          if (pktsLeft[i] > 0) flitsLeft[i] = pktLen[i];
        end
      end
    end
  endtask

  task automatic setRdy();
    bus.RDY_tx = !(cyc >= stallFrom && cyc <= stallTo);
  endtask

  function automatic logic anyActive();
    logic a = 1'b0;
    for (int i = 0; i < 4; i++) if (flitsLeft[i] > 0) a = 1'b1;
    return a;
  endfunction

  // One clock: log at the falling edge, then update inputs just after the
  // rising edge
  task automatic runCycle();
    logic [3:0] fire;
    @(negedge clk);
    if (cyc < 64) begin
      enLog[cyc]    = bus.EN_tx;
      busyLog[cyc]  = busy;
      grantLog[cyc] = grant_id;
      readyLog[cyc] = bus.req_ready;
      dataLog[cyc]  = bus.tx_data;
    end
    if (bus.EN_tx && trData.size() < 256) begin
      trData.push_back(bus.tx_data);
      trCycle.push_back(cyc);
    end
    fire = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    advanceLanes(fire);
    cyc++;
    setRdy();
    driveLanes();
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) runCycle();
  endtask

  // Reset, with lanes idle, and leave just after a rising edge as cycle 0
  task automatic startTest();
    clearLanes();
    stallFrom = -1;
    stallTo   = -1;
    stat_sel  = 2'd0;
    bus.RDY_tx = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    trData.delete();
    trCycle.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    stat_sel = 2'd0;
    bus.RDY_tx = 1'b1;
    clearLanes();
    #12;

    // Reset state
    checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_en_tx", 32'(bus.EN_tx), 32'h0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_tx_data", bus.tx_data, 32'h0);
    checkOutput("rst_stat_cnt", 32'(stat_cnt), 32'h0);

    // Single 3-flit packet from lane 0
    startTest();
    applyStimulus(0, 32'hA0, 3, 1);
    runCycles(5);
    checkOutput("t1_idle_busy", 32'(busyLog[0]), 32'h0);
    checkOutput("t1_idle_en", 32'(enLog[0]), 32'h0);
    checkOutput("t1_grant", 32'(grantLog[1]), 32'h0);
    checkOutput("t1_busy", 32'(busyLog[1]), 32'h1);
    checkOutput("t1_ready", 32'(readyLog[1]), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("t1_en_c%0d", c), 32'(enLog[c]), 32'h1);
      checkOutput($sformatf("t1_data_c%0d", c), dataLog[c], 32'hA0 + 32'(c - 1));
    end
    checkOutput("t1_done_busy", 32'(busyLog[4]), 32'h0);
    checkOutput("t1_done_en", 32'(enLog[4]), 32'h0);
    checkOutput("t1_done_data", dataLog[4], 32'h0);

    // All lanes continuously requesting single-flit packets
    startTest();
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'((i + 1) * 256), 1, 100);
    runCycles(10);
    checkOutput("t2_grant_c1", 32'(grantLog[1]), 32'h0);
    checkOutput("t2_grant_c3", 32'(grantLog[3]), 32'h1);
    checkOutput("t2_grant_c5", 32'(grantLog[5]), 32'h2);
    checkOutput("t2_grant_c7", 32'(grantLog[7]), 32'h3);
    checkOutput("t2_grant_c9", 32'(grantLog[9]), 32'h0);
    for (int c = 0; c < 10; c += 2) begin
      checkOutput($sformatf("t2_bubble_c%0d", c), 32'(enLog[c]), 32'h0);
    end
    checkOutput("t2_xfers", 32'(trData.size()), 32'd5);
    checkOutput("t2_data_c7", dataLog[7], 32'h400);
    checkOutput("t2_data_c9", dataLog[9], 32'h101);

    // Lane 1 long packet split by the burst limit, lane 2 interleaved
    startTest();
    applyStimulus(1, 32'h200, 20, 1);
    applyStimulus(2, 32'h300, 2, 1);
    runCycles(28);
    checkOutput("t3_xfers", 32'(trData.size()), 32'd22);
    if (trData.size() == 22) begin
      for (int k = 0; k < 22; k++) begin
        logic [31:0] exp;
        if (k < 8)       exp = 32'h200 + 32'(k);
        else if (k < 10) exp = 32'h300 + 32'(k - 8);
        else             exp = 32'h200 + 32'(k - 2);
        checkOutput($sformatf("t3_flit%0d", k), trData[k], exp);
      end
      checkOutput("t3_cyc_first_l2", 32'(trCycle[8]), 32'd10);
      checkOutput("t3_cyc_resume_l1", 32'(trCycle[10]), 32'd13);
      checkOutput("t3_cyc_tail_l1", 32'(trCycle[18]), 32'd22);
    end
    checkOutput("t3_bubble", 32'(enLog[9]), 32'h0);
    checkOutput("t3_grant_l2", 32'(grantLog[10]), 32'h2);

    // Statistics read after the previous traffic (lane 1 sent 20 flits)
    stat_sel = 2'd1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
`ifdef LVDS_ARB_STATS_EN
    checkOutput("t3_stat_l1", 32'(stat_cnt), 32'd20);
`else
    checkOutput("t3_stat_off", 32'(stat_cnt), 32'd0);
`endif

    // Serializer back-pressure mid-packet
    startTest();
    stallFrom = 3;
    stallTo   = 7;
    applyStimulus(2, 32'h300, 10, 1);
    runCycles(18);
    for (int c = 3; c <= 7; c++) begin
      checkOutput($sformatf("t4_en_c%0d", c), 32'(enLog[c]), 32'h0);
      checkOutput($sformatf("t4_ready_c%0d", c), 32'(readyLog[c]), 32'h0);
      checkOutput($sformatf("t4_busy_c%0d", c), 32'(busyLog[c]), 32'h1);
      checkOutput($sformatf("t4_grant_c%0d", c), 32'(grantLog[c]), 32'h2);
    end
    checkOutput("t4_xfers", 32'(trData.size()), 32'd10);
    if (trData.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        checkOutput($sformatf("t4_flit%0d", k), trData[k], 32'h300 + 32'(k));
      end
      checkOutput("t4_cyc_resume", 32'(trCycle[2]), 32'd8);
      checkOutput("t4_cyc_after_burst", 32'(trCycle[8]), 32'd15);
    end
    checkOutput("t4_burst_release", 32'(enLog[14]), 32'h0);

    // Reset asserted after 2 of 4 flits
    startTest();
    applyStimulus(0, 32'h100, 4, 1);
    applyStimulus(1, 32'h200, 1, 1);
    runCycles(3);
    checkOutput("t5_pre_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
    checkOutput("t5_rst_en", 32'(bus.EN_tx), 32'h0);
    checkOutput("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("t5_rst_data", bus.tx_data, 32'h0);
    checkOutput("t5_rst_grant", 32'(grant_id), 32'h0);
    clearLanes();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    trData.delete();
    trCycle.delete();
    applyStimulus(0, 32'h180, 2, 1);
    applyStimulus(1, 32'h200, 1, 1);
    runCycles(3);
    checkOutput("t5_after_grant", 32'(grantLog[1]), 32'h0);
    checkOutput("t5_after_en", 32'(enLog[1]), 32'h1);
    checkOutput("t5_after_data", dataLog[1], 32'h180);

`ifdef LVDS_ARB_STATS_EN
    // Saturation: 0x10000 transfers from lane 3
    startTest();
    applyStimulus(3, 32'h0, 8, 8192);
    for (int k = 0; k < 80000 && anyActive(); k++) runCycle();
    checkOutput("t6_finished", 32'(anyActive()), 32'h0);
    stat_sel = 2'd3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("t6_stat_l3", 32'(stat_cnt), 32'hFFFF);
    stat_sel = 2'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("t6_stat_l0", 32'(stat_cnt), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
